// File: rtl/m_trap_handle_regs.sv
// m_trap_handle_regs
//   Machine-mode trap-handling CSRs: mstatus (MIE/MPIE), mscratch, mepc,
//   mcause and mtval. Sequences trap entry and mret, and produces a
//   one-cycle redirect to the fetch stage.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mtvec_in          {BASE[31:2], MODE[1:0]} from the setup registers
//   csr_addr/op/wdata CSR access (op: 00 none, 01 write, 10 set, 11 clear)
//   csr_rdata/hit     combinational read data and address-match flag
//   trap_req/cause/pc/val  trap entry request and its information
//   mret_req          mret retiring this cycle
//   busy              FSM not in IDLE
//   redirect_valid/pc one-cycle fetch redirect
//   mstatus_mie       global machine interrupt enable
module m_trap_handle_regs #(
  parameter int          XLEN          = 32,
  parameter logic [11:0] ADDR_MSTATUS  = 12'h300,
  parameter logic [11:0] ADDR_MSCRATCH = 12'h340,
  parameter logic [11:0] ADDR_MEPC     = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE   = 12'h342,
  parameter logic [11:0] ADDR_MTVAL    = 12'h343
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_hit,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_req,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie
);

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            sel_mstatus, sel_mscratch, sel_mepc, sel_mcause, sel_mtval;
  logic            csr_we;
  logic [XLEN-1:0] csr_new;
  logic            trap_fire, mret_fire;
  logic [XLEN-1:0] trap_base, trap_target;
  logic [XLEN-1:0] mstatus_view;

  // Interrupt cause bit 30 never contributes to the vector offset.
  logic unused_cause_bit;
  assign unused_cause_bit = trap_cause[30];

  // ---------------- address decode and read mux ----------------
  assign sel_mstatus  = (csr_addr == ADDR_MSTATUS);
  assign sel_mscratch = (csr_addr == ADDR_MSCRATCH);
  assign sel_mepc     = (csr_addr == ADDR_MEPC);
  assign sel_mcause   = (csr_addr == ADDR_MCAUSE);
  assign sel_mtval    = (csr_addr == ADDR_MTVAL);
  assign csr_hit      = sel_mstatus | sel_mscratch | sel_mepc | sel_mcause | sel_mtval;

  // MPP is hardwired to machine mode (2'b11).
  assign mstatus_view = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    csr_rdata = '0;
    if (sel_mstatus)  csr_rdata = mstatus_view;
    if (sel_mscratch) csr_rdata = mscratch_q;
    if (sel_mepc)     csr_rdata = mepc_q;
    if (sel_mcause)   csr_rdata = mcause_q;
    if (sel_mtval)    csr_rdata = mtval_q;
  end

  // Read-modify-write value; set/clear with a zero mask still count as writes.
  always_comb begin
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  assign csr_we = csr_hit && (csr_op != 2'b00);

  // ---------------- trap / mret sequencing ----------------
  assign trap_fire = (state_q == IDLE) && trap_req;
  assign mret_fire = (state_q == IDLE) && mret_req && !trap_req;

  assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};
  // Only vectored mode with an interrupt cause offsets from BASE.
  assign trap_target = (mtvec_in[1:0] == 2'b01 && trap_cause[XLEN-1])
                       ? trap_base + {trap_cause[29:0], 2'b00}
                       : trap_base;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (trap_fire || mret_fire) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic (decoded from the state flop, so it is glitch-free)
  always_comb begin
    busy           = (state_q != IDLE);
    redirect_valid = (state_q == REDIRECT);
  end

  assign redirect_pc = redirect_pc_q;
  assign mstatus_mie = mie_q;

  // ---------------- register next-state ----------------
  always_comb begin
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mscratch_d    = mscratch_q;
    redirect_pc_d = redirect_pc_q;

    // Trap/mret updates take priority; colliding CSR writes to the
    // trap-state registers are dropped, mscratch is independent.
    if (trap_fire) begin
      mepc_d        = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d      = trap_cause;
      mtval_d       = trap_val;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      redirect_pc_d = trap_target;
    end else if (mret_fire) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      redirect_pc_d = mepc_q;
    end else if (csr_we) begin
      if (sel_mstatus) begin
        mie_d  = csr_new[3];
        mpie_d = csr_new[7];
      end
      if (sel_mepc)   mepc_d   = {csr_new[XLEN-1:2], 2'b00};
      if (sel_mcause) mcause_d = csr_new;
      if (sel_mtval)  mtval_d  = csr_new;
    end

    if (csr_we && sel_mscratch) mscratch_d = csr_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule
